eaglesong_nonce_search: RTL and testbench

EAGLESONG_NONCE_SEARCH -- requirements
Module: eaglesong_nonce_search

---
 rtl/eaglesong_nonce_search.sv | 174 +++++++++++++++++
 tb/tb_eaglesong_nonce_search.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eaglesong_nonce_search.sv
// ---------------------------------------------------------------------------
// eaglesong_nonce_search
//   Sequences a nonce search over an external Eaglesong digest stage. Each
//   attempt launches the digest on {nonce, header}, waits for its result and
//   compares it (unsigned) against the target. The search ends on a hit, on
//   exhausting nonce_count attempts, on a digest timeout, or on cmd_abort.
//
// Parameters
//   TIMEOUT_CYCLES         max WAIT cycles per attempt before giving up
// Ports
//   clk, rst               rising-edge clock, async active-high reset
//   cmd_start, cmd_abort   start a search / abandon the current one
//   header, target         message prefix and hit threshold
//   nonce_start/count      first nonce and number of nonces to try
//   dig_*                  handshake with the digest stage
//   busy, done             search in progress / finished (sticky)
//   found, aborted,
//   timeout_err            termination cause
//   found_nonce/digest     hit nonce and digest
//   attempts               digests compared so far
// ---------------------------------------------------------------------------
module eaglesong_nonce_search #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_start,
  input  logic         cmd_abort,
  input  logic [223:0] header,
  input  logic [255:0] target,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_count,
  output logic [255:0] dig_input_val,
  output logic [6:0]   dig_input_length_bytes,
  output logic         dig_start_eval,
  input  logic [255:0] dig_output_val,
  input  logic         dig_eval_output_ready,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         aborted,
  output logic         timeout_err,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_digest,
  output logic [31:0]  attempts
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SETTLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [31:0] LP_WAIT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t         r_state;
  logic [223:0]   r_header;
  logic [255:0]   r_target;
  logic [31:0]    r_nonce;
  logic [31:0]    r_count;
  logic [31:0]    r_attempts;
  logic [31:0]    r_wait_cnt;
  logic           r_settle;
  logic           r_found;
  logic           r_aborted;
  logic           r_timeout;
  logic [31:0]    r_found_nonce;
  logic [255:0]   r_found_digest;

  logic           w_active;
  logic           w_hit;
  logic           w_last;

  assign w_active = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_hit    = (dig_output_val <= r_target);
  // Exhaustion is judged on the attempt count after this CHECK's increment.
  assign w_last   = ((r_attempts + 32'd1) == r_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_header       <= '0;
      r_target       <= '0;
      r_nonce        <= '0;
      r_count        <= '0;
      r_attempts     <= '0;
      r_wait_cnt     <= '0;
      r_settle       <= 1'b0;
      r_found        <= 1'b0;
      r_aborted      <= 1'b0;
      r_timeout      <= 1'b0;
      r_found_nonce  <= '0;
      r_found_digest <= '0;
    end else if (w_active && cmd_abort) begin
      // Abort outranks whatever the current state would have done this edge.
      r_state   <= ST_DONE;
      r_aborted <= 1'b1;
      r_found   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (cmd_start) begin
            r_header       <= header;
            r_target       <= target;
            r_nonce        <= nonce_start;
            r_count        <= nonce_count;
            r_attempts     <= '0;
            r_wait_cnt     <= '0;
            r_found        <= 1'b0;
            r_aborted      <= 1'b0;
            r_timeout      <= 1'b0;
            r_found_nonce  <= '0;
            r_found_digest <= '0;
            r_state        <= (nonce_count == '0) ? ST_DONE : ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_settle <= 1'b0;
          r_state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Two cycles during which a stale ready from the last run is ignored.
          if (r_settle) begin
            r_wait_cnt <= '0;
            r_state    <= ST_WAIT;
          end else begin
            r_settle <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (dig_eval_output_ready) begin
            r_state <= ST_CHECK;
          end else if (r_wait_cnt == LP_WAIT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
        end
        ST_CHECK: begin
          r_attempts <= r_attempts + 32'd1;
          if (w_hit) begin
            r_found        <= 1'b1;
            r_found_nonce  <= r_nonce;
            r_found_digest <= dig_output_val;
            r_state        <= ST_DONE;
          end else if (w_last) begin
            r_state <= ST_DONE;
          end else begin
            r_nonce <= r_nonce + 32'd1;
            r_state <= ST_LAUNCH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dig_input_val          = {r_nonce, r_header};
  assign dig_input_length_bytes = 7'd32;
  assign dig_start_eval         = (r_state == ST_LAUNCH);
  assign busy                   = w_active;
  assign done                   = (r_state == ST_DONE);
  assign found                  = r_found;
  assign aborted                = r_aborted;
  assign timeout_err            = r_timeout;
  assign found_nonce            = r_found_nonce;
  assign found_digest           = r_found_digest;
  assign attempts               = r_attempts;

endmodule

// File: tb/tb_eaglesong_nonce_search.sv
// ---------------------------------------------------------------------------
// tb_eaglesong_nonce_search
//   Directed bench for eaglesong_nonce_search. A behavioural digest stage
//   answers each launch: ready keeps its old level for two cycles after the
//   launch (to look like a stale result), then drops, then rises resp_lat
//   cycles after the launch carrying either the hit or the miss digest.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eaglesong_nonce_search;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_start = 1'b0;
  logic         cmd_abort = 1'b0;
  logic [223:0] header = '0;
  logic [255:0] target = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_count = '0;
  logic [255:0] dig_input_val;
  logic [6:0]   dig_input_length_bytes;
  logic         dig_start_eval;
  logic [255:0] dig_output_val = '0;
  logic         dig_eval_output_ready = 1'b0;
  logic         busy, done, found, aborted, timeout_err;
  logic [31:0]  found_nonce;
  logic [255:0] found_digest;
  logic [31:0]  attempts;

  eaglesong_nonce_search #(.TIMEOUT_CYCLES(64)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .cmd_start             (cmd_start),
    .cmd_abort             (cmd_abort),
    .header                (header),
    .target                (target),
    .nonce_start           (nonce_start),
    .nonce_count           (nonce_count),
    .dig_input_val         (dig_input_val),
    .dig_input_length_bytes(dig_input_length_bytes),
    .dig_start_eval        (dig_start_eval),
    .dig_output_val        (dig_output_val),
    .dig_eval_output_ready (dig_eval_output_ready),
    .busy                  (busy),
    .done                  (done),
    .found                 (found),
    .aborted               (aborted),
    .timeout_err           (timeout_err),
    .found_nonce           (found_nonce),
    .found_digest          (found_digest),
    .attempts              (attempts)
  );

  always #5 clk = ~clk;

  localparam logic [223:0] HDR =
    224'h01234567_89ABCDEF_00112233_44556677_8899AABB_CCDDEEFF_13579BDF;

  int n_chk = 0;
  int n_err = 0;

  // Digest-stage model controls and launch log.
  logic         resp_en = 1'b1;
  int           resp_lat = 4;
  logic [31:0]  resp_hit_nonce = '0;
  logic [255:0] resp_hit_digest = '0;
  logic [255:0] resp_miss_digest = '0;
  int           n_launch = 0;
  logic [31:0]  launch_log [8];
  logic [223:0] hdr_log = '0;
  logic [31:0]  cur_nonce = '0;
  int           k = 100;

  task automatic check_val(input string tag, input logic [255:0] got,
                           input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (dig_start_eval) begin
        if (n_launch < 8) launch_log[n_launch] = dig_input_val[255:224];
        hdr_log   = dig_input_val[223:0];
        cur_nonce = dig_input_val[255:224];
        n_launch++;
        k = 0;
      end else begin
        if (k < 100) k++;
        if (k == 2) dig_eval_output_ready = 1'b0;
        if (k == resp_lat && resp_en) begin
          dig_output_val = (cur_nonce == resp_hit_nonce) ? resp_hit_digest
                                                         : resp_miss_digest;
          dig_eval_output_ready = 1'b1;
        end
      end
    end
  end

  task automatic start_search(input logic [255:0] t, input logic [31:0] ns,
                              input logic [31:0] nc);
    @(negedge clk);
    #1;
    header      = HDR;
    target      = t;
    nonce_start = ns;
    nonce_count = nc;
    n_launch    = 0;
    cmd_start   = 1'b1;
    @(negedge clk);
    cmd_start   = 1'b0;
  endtask

  // Returns the number of cycles after the start edge until done is seen.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_busy",  256'(busy), 256'd0);
    check_val("rst_done",  256'(done), 256'd0);
    check_val("rst_start", 256'(dig_start_eval), 256'd0);
    check_val("rst_len",   256'(dig_input_length_bytes), 256'd32);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_flags", 256'({found, aborted, timeout_err}), 256'd0);
    check_val("idle_attempts", 256'(attempts), 256'd0);

    // Empty search: done one cycle after start, no launch
    start_search('1, 32'd9, 32'd0);
    wait_done(cyc);
    check_val("empty_cyc", 256'(cyc), 256'd0);
    check_val("empty_done", 256'(done), 256'd1);
    check_val("empty_launch", 256'(n_launch), 256'd0);
    check_val("empty_attempts", 256'(attempts), 256'd0);

    // Hit on first attempt
    resp_en = 1'b1; resp_lat = 4;
    resp_hit_nonce = 32'd5; resp_hit_digest = 256'h1234; resp_miss_digest = 256'h1234;
    start_search('1, 32'd5, 32'd10);
    wait_done(cyc);
    check_val("hit1_cyc", 256'(cyc), 256'd6);
    check_val("hit1_launch", 256'(n_launch), 256'd1);
    check_val("hit1_nonce_in", 256'(launch_log[0]), 256'd5);
    check_val("hit1_hdr_in", 256'(hdr_log), 256'(HDR));
    check_val("hit1_found", 256'(found), 256'd1);
    check_val("hit1_fnonce", 256'(found_nonce), 256'd5);
    check_val("hit1_fdigest", found_digest, 256'h1234);
    check_val("hit1_attempts", 256'(attempts), 256'd1);
    check_val("hit1_busy", 256'(busy), 256'd0);

    // Wrap-around, exhaustion with no hit
    resp_hit_nonce = 32'h1234_5678; resp_miss_digest = 256'h1;
    start_search('0, 32'hFFFF_FFFE, 32'd3);
    wait_done(cyc);
    check_val("wrap_cyc", 256'(cyc), 256'd18);
    check_val("wrap_launch", 256'(n_launch), 256'd3);
    check_val("wrap_n0", 256'(launch_log[0]), 256'hFFFF_FFFE);
    check_val("wrap_n1", 256'(launch_log[1]), 256'hFFFF_FFFF);
    check_val("wrap_n2", 256'(launch_log[2]), 256'h0);
    check_val("wrap_found", 256'(found), 256'd0);
    check_val("wrap_attempts", 256'(attempts), 256'd3);
    check_val("wrap_done", 256'(done), 256'd1);

    // Hit on equality at third attempt; misses have the MSB set
    resp_hit_nonce = 32'd12; resp_hit_digest = 256'h100;
    resp_miss_digest = {1'b1, 255'd0};
    start_search(256'h100, 32'd10, 32'd5);
    wait_done(cyc);
    check_val("eq_launch", 256'(n_launch), 256'd3);
    check_val("eq_found", 256'(found), 256'd1);
    check_val("eq_fnonce", 256'(found_nonce), 256'd12);
    check_val("eq_fdigest", found_digest, 256'h100);
    check_val("eq_attempts", 256'(attempts), 256'd3);

    // Abort in WAIT, late hit afterwards
    resp_lat = 6; resp_hit_nonce = 32'd40; resp_hit_digest = 256'h0;
    start_search('1, 32'd40, 32'd4);
    repeat (3) @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    check_val("abort_flag", 256'(aborted), 256'd1);
    check_val("abort_done", 256'(done), 256'd1);
    check_val("abort_busy", 256'(busy), 256'd0);
    repeat (6) @(negedge clk);
    check_val("abort_late_found", 256'(found), 256'd0);
    check_val("abort_late_attempts", 256'(attempts), 256'd0);
    check_val("abort_late_fdigest", found_digest, 256'd0);
    check_val("abort_late_flag", 256'(aborted), 256'd1);

    // Stuck digest: timeout after 1+2+64 cycles
    resp_en = 1'b0;
    start_search('1, 32'd7, 32'd3);
    wait_done(cyc);
    check_val("tmo_cyc", 256'(cyc), 256'd67);
    check_val("tmo_flag", 256'(timeout_err), 256'd1);
    check_val("tmo_attempts", 256'(attempts), 256'd0);
    check_val("tmo_found", 256'(found), 256'd0);

    // Async reset mid-WAIT with stale ready left high
    resp_en = 1'b1; resp_lat = 20;
    start_search('1, 32'd60, 32'd4);
    repeat (3) @(negedge clk);
    #1;
    check_val("pre_rst_busy", 256'(busy), 256'd1);
    dig_eval_output_ready = 1'b1;
    rst = 1'b1;
    #1;
    check_val("arst_busy", 256'(busy), 256'd0);
    check_val("arst_done", 256'(done), 256'd0);
    check_val("arst_nonce", 256'(dig_input_val[255:224]), 256'd0);
    check_val("arst_start", 256'(dig_start_eval), 256'd0);
    #1;
    rst = 1'b0;
    resp_lat = 4; resp_hit_nonce = 32'd77; resp_hit_digest = 256'h4FF;
    resp_miss_digest = '1;
    start_search(256'h500, 32'd77, 32'd2);
    wait_done(cyc);
    check_val("post_rst_cyc", 256'(cyc), 256'd6);
    check_val("post_rst_found", 256'(found), 256'd1);
    check_val("post_rst_fnonce", 256'(found_nonce), 256'd77);
    check_val("post_rst_fdigest", found_digest, 256'h4FF);
    check_val("post_rst_attempts", 256'(attempts), 256'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
